// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus transaction with stall, store lane
// steering and load extraction. Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    output logic        mem_stall,
    output logic [31:0] mem_data,
    output logic        mem_misalign,
    output logic        mem_bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic        w_is_mem;
    logic        w_aligned;
    logic        w_start;
    logic        w_finish;
    logic        w_timeout;
    logic        w_stall;
    logic        w_misalign;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem_data;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_is_load;

    assign w_is_mem = ex_mem_read | ex_mem_write;

    always_comb begin
        w_aligned = 1'b1;
        case (ex_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~ex_alu_result[0];
            default: w_aligned = (ex_alu_result[1:0] == 2'b00);
        endcase
    end

    // Qualified by reset so the combinational outputs also read 0 while reset is held.
    assign w_start = reset & ex_valid & w_is_mem & w_aligned;

    // Store lane steering; a simultaneous read+write is treated as a store.
    always_comb begin
        w_wdata = ex_store_data;
        w_be    = 4'b1111;
        if (ex_mem_write) begin
            case (ex_size)
                2'b00: begin
                    w_wdata = {4{ex_store_data[7:0]}};
                    w_be    = 4'b0001 << ex_alu_result[1:0];
                end
                2'b01: begin
                    w_wdata = {2{ex_store_data[15:0]}};
                    w_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = ex_store_data;
                    w_be    = 4'b1111;
                end
            endcase
        end else begin
            w_wdata = 32'h0;
            w_be    = 4'b1111;
        end
    end

    // Load extraction uses the lane/size captured at request time.
    always_comb begin
        w_byte = dbus_rdata[7:0];
        case (r_lane)
            2'd0:    w_byte = dbus_rdata[7:0];
            2'd1:    w_byte = dbus_rdata[15:8];
            2'd2:    w_byte = dbus_rdata[23:16];
            default: w_byte = dbus_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (r_size)
            2'b00:   w_load_ext = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_ext = dbus_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    // An ack arriving on the limit cycle takes priority over the abort.
    assign w_timeout = (r_state == S_BUSY) && !dbus_ack
                       && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (r_state != S_BUSY) begin
                r_cnt <= '0;
            end else if (!dbus_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign mem_bus_err = r_bus_err;
`else
    assign w_timeout   = 1'b0;
    assign mem_bus_err = 1'b0;
`endif

    assign w_finish = (r_state == S_BUSY) && (dbus_ack || w_timeout);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_misalign   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_misalign = reset & ex_valid & w_is_mem & ~w_aligned;
                if (w_start) begin
                    w_stall      = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (dbus_ack || w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // EX/MEM still holds the finished instruction, so no restart here.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_be       <= 4'h0;
            r_mem_data <= 32'h0;
            r_lane     <= 2'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_is_load  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_start) begin
                r_req      <= 1'b1;
                r_we       <= ex_mem_write;
                r_addr     <= {ex_alu_result[31:2], 2'b00};
                r_wdata    <= w_wdata;
                r_be       <= w_be;
                r_lane     <= ex_alu_result[1:0];
                r_size     <= ex_size;
                r_unsigned <= ex_unsigned;
                r_is_load  <= ~ex_mem_write;
            end else if (w_finish) begin
                r_req <= 1'b0;
                if (r_is_load) begin
                    r_mem_data <= dbus_ack ? w_load_ext : 32'h0;
                end
            end
        end
    end

    assign mem_stall    = w_stall;
    assign mem_misalign = w_misalign;
    assign mem_data     = r_mem_data;
    assign dbus_req     = r_req;
    assign dbus_we      = r_we;
    assign dbus_addr    = r_addr;
    assign dbus_wdata   = r_wdata;
    assign dbus_be      = r_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a mem_data scoreboard queue,
// plus hand sequences for reset-in-flight, non-memory and timeout behaviour.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [1:0]  ex_size = 2'b00;
    logic        ex_unsigned = 1'b0;
    logic [31:0] ex_alu_result = 32'h0;
    logic [31:0] ex_store_data = 32'h0;
    logic        mem_stall;
    logic [31:0] mem_data;
    logic        mem_misalign;
    logic        mem_bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_rdata = 32'h0;
    logic        dbus_ack = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data),
        .mem_stall    (mem_stall),
        .mem_data     (mem_data),
        .mem_misalign (mem_misalign),
        .mem_bus_err  (mem_bus_err),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_wdata   (dbus_wdata),
        .dbus_be      (dbus_be),
        .dbus_rdata   (dbus_rdata),
        .dbus_ack     (dbus_ack)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_mem;
        logic        e_mis;
    } vec_t;

    localparam int NVEC = 13;
    vec_t        vecs[NVEC];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_valid      = 1'b1;
        ex_mem_read   = v.rd;
        ex_mem_write  = v.wr;
        ex_size       = v.size;
        ex_unsigned   = v.uns;
        ex_alu_result = v.addr;
        ex_store_data = v.sdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          busy;
        int          stalls;
        bit          done;
        logic [31:0] e;
        @(negedge clk);
        drive(v);
        #1;
        if (v.e_mis) begin
            chk("misalign_pulse", mem_misalign, 1'b1);
            chk("misalign_stall", mem_stall, 1'b0);
            @(negedge clk);
            chk("misalign_req", dbus_req, 1'b0);
            chk("misalign_mem", mem_data, v.e_mem);
            ex_valid = 1'b0;
        end else begin
            chk("start_stall", mem_stall, 1'b1);
            chk("start_misalign", mem_misalign, 1'b0);
            exp_q.push_back(v.e_mem);
            stalls = 1;
            busy   = 0;
            done   = 1'b0;
            while (!done && busy < 64) begin
                @(negedge clk);
                chk("busy_req", dbus_req, 1'b1);
                chk("busy_addr", dbus_addr, v.e_addr);
                chk("busy_we", dbus_we, v.e_we);
                chk("busy_be", dbus_be, v.e_be);
                if (v.e_we) chk("busy_wdata", dbus_wdata, v.e_wdata);
                if (mem_stall) stalls++;
                if (busy == v.waits) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = v.rdata;
                    done       = 1'b1;
                end else begin
                    dbus_ack   = 1'b0;
                    dbus_rdata = $urandom;
                end
                busy++;
            end
            @(negedge clk);
            dbus_ack = 1'b0;
            // ex_valid still high here: the DONE cycle must not restart.
            chk("done_stall", mem_stall, 1'b0);
            chk("done_req", dbus_req, 1'b0);
            chk("done_bus_err", mem_bus_err, 1'b0);
            chk("stall_cycles", stalls, v.waits + 2);
            e = exp_q.pop_front();
            chk("mem_data", mem_data, e);
            ex_valid = 1'b0;
        end
        $display("txn %0d addr=%h rd=%0b wr=%0b size=%0d mem_data=%h", idx, v.addr, v.rd, v.wr,
                 v.size, mem_data);
    endtask

    initial begin
        int   cnt;
        vec_t v;
        //         rd wr size uns addr          sdata         rdata         w  e_addr        we e_wdata       be     e_mem         mis
        vecs[0]  = '{1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 0, 32'h0,        4'hF, 32'hDEADBEEF, 0};
        vecs[1]  = '{1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80FFFF12, 1, 32'h100, 0, 32'h0,        4'hF, 32'hFFFFFF80, 0};
        vecs[2]  = '{1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80FFFF12, 0, 32'h100, 0, 32'h0,        4'hF, 32'h00000080, 0};
        vecs[3]  = '{0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h0,        3, 32'h100, 1, 32'hABCDABCD, 4'hC, 32'h00000080, 0};
        vecs[4]  = '{0, 1, 2'b00, 0, 32'h205, 32'h123456A5, 32'h0,        0, 32'h204, 1, 32'hA5A5A5A5, 4'h2, 32'h00000080, 0};
        vecs[5]  = '{1, 0, 2'b01, 0, 32'h002, 32'h0,        32'h80017FFF, 2, 32'h000, 0, 32'h0,        4'hF, 32'hFFFF8001, 0};
        vecs[6]  = '{1, 0, 2'b01, 1, 32'h000, 32'h0,        32'h8001F234, 0, 32'h000, 0, 32'h0,        4'hF, 32'h0000F234, 0};
        vecs[7]  = '{1, 0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        0, 32'h0,   0, 32'h0,        4'h0, 32'h0000F234, 1};
        vecs[8]  = '{1, 0, 2'b01, 0, 32'h103, 32'h0,        32'h0,        0, 32'h0,   0, 32'h0,        4'h0, 32'h0000F234, 1};
        vecs[9]  = '{1, 1, 2'b11, 0, 32'h30C, 32'h11223344, 32'h55555555, 1, 32'h30C, 1, 32'h11223344, 4'hF, 32'h0000F234, 0};
        vecs[10] = '{1, 0, 2'b00, 0, 32'h301, 32'h0,        32'h00007F00, 0, 32'h300, 0, 32'h0,        4'hF, 32'h0000007F, 0};
        vecs[11] = '{0, 1, 2'b10, 0, 32'h302, 32'hCAFEF00D, 32'h0,        0, 32'h0,   0, 32'h0,        4'h0, 32'h0000007F, 1};
        vecs[12] = '{1, 0, 2'b00, 0, 32'h302, 32'h0,        32'h00AB0000, 1, 32'h300, 0, 32'h0,        4'hF, 32'hFFFFFFAB, 0};

        // Reset state, with a valid load presented to prove reset masks stall
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_size = 2'b10; ex_alu_result = 32'h40;
        #2;
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_req", dbus_req, 1'b0);
        chk("rst_we", dbus_we, 1'b0);
        chk("rst_addr", dbus_addr, 32'h0);
        chk("rst_wdata", dbus_wdata, 32'h0);
        chk("rst_be", dbus_be, 4'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_misalign", mem_misalign, 1'b0);
        chk("rst_bus_err", mem_bus_err, 1'b0);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Non-memory instruction: no stall, no bus access, mem_data held
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_alu_result = 32'h101;
        #1;
        chk("nonmem_stall", mem_stall, 1'b0);
        chk("nonmem_misalign", mem_misalign, 1'b0);
        @(negedge clk);
        chk("nonmem_req", dbus_req, 1'b0);
        chk("nonmem_mem", mem_data, 32'hFFFFFFAB);
        ex_valid = 1'b0;
        $display("txn nonmem mem_data=%h", mem_data);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after TIMEOUT busy cycles with one error pulse and mem_data=0
        v = '{1, 0, 2'b10, 0, 32'h500, 32'h0, 32'h0, 0, 32'h500, 0, 32'h0, 4'hF, 32'h0, 0};
        @(negedge clk);
        drive(v);
        exp_q.push_back(32'h0);
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (!dbus_req) break;
            cnt++;
        end
        chk("timeout_busy_cycles", cnt, 4);
        chk("timeout_bus_err", mem_bus_err, 1'b1);
        chk("timeout_stall", mem_stall, 1'b0);
        chk("timeout_mem", mem_data, exp_q.pop_front());
        ex_valid = 1'b0;
        @(negedge clk);
        chk("timeout_err_pulse", mem_bus_err, 1'b0);
        $display("txn timeout busy=%0d mem_data=%h", cnt, mem_data);
`else
        // Without the timeout feature a long wait still completes normally
        v = '{1, 0, 2'b10, 0, 32'h500, 32'h0, 32'h0BADF00D, 20, 32'h500, 0, 32'h0, 4'hF, 32'h0BADF00D, 0};
        run_vec(100, v);
`endif

        // Reset while BUSY: request drops at once, a late ack is ignored
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_size = 2'b10;
        ex_alu_result = 32'h400;
        @(negedge clk);
        chk("inflight_req", dbus_req, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_req", dbus_req, 1'b0);
        chk("arst_stall", mem_stall, 1'b0);
        chk("arst_mem", mem_data, 32'h0);
        chk("arst_addr", dbus_addr, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        dbus_ack = 1'b1; dbus_rdata = 32'h12345678;
        #1;
        chk("late_ack_stall", mem_stall, 1'b0);
        @(negedge clk);
        dbus_ack = 1'b0;
        chk("late_ack_req", dbus_req, 1'b0);
        chk("late_ack_mem", mem_data, 32'h0);
        @(negedge clk);
        chk("late_ack_idle", mem_stall, 1'b0);
        $display("txn reset_inflight mem_data=%h", mem_data);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit between the EX/MEM pipeline register and the MEM/WB register.
- Takes the EX/MEM address, store data and control, and runs a req/ack transaction on the data-memory bus.
- Stalls the pipeline while the access is in flight.
- Presents size-aligned, sign/zero-extended load data as mem_data to the MEM/WB register.

Parameters:
- TIMEOUT, 16, bus wait cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ex_valid  input  1  EX/MEM holds a valid instruction
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_size  input  2  00 byte, 01 half, 10/11 word
- ex_unsigned  input  1  zero-extend loads when 1
- ex_alu_result  input  32  byte address
- ex_store_data  input  32  store data, right-justified
- mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_data  output  32  extended load data to MEM/WB
- mem_misalign  output  1  one-cycle misaligned-access pulse
- mem_bus_err  output  1  one-cycle timeout pulse
- dbus_req  output  1  bus request
- dbus_we  output  1  write enable
- dbus_addr  output  32  word address, {addr[31:2],2'b00}
- dbus_wdata  output  32  lane-replicated store data
- dbus_be  output  4  byte enables
- dbus_rdata  input  32  read data, valid with ack
- dbus_ack  input  1  transfer complete

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - All outputs 0: mem_data, dbus_addr, dbus_wdata, dbus_be, dbus_req, dbus_we, mem_stall, pulses.
  - An in-flight request drops immediately; a later ack is ignored.
- start = ex_valid & (ex_mem_read | ex_mem_write) & aligned.
- Alignment:
  - Half needs addr[0]=0.
  - Word needs addr[1:0]=0.
  - Byte is always aligned.
- State IDLE:
  - start=1: mem_stall=1 combinationally. On the clock, latch dbus_addr/we/wdata/be and the load info (lane, size, unsigned); set dbus_req=1; go to BUSY.
  - Misaligned access with ex_valid=1: mem_misalign=1 for this cycle only; no bus access; no stall; mem_data unchanged.
  - Non-memory instruction: no stall; mem_data holds its previous value.
- State BUSY:
  - mem_stall=1; dbus_req stays 1.
  - dbus_addr, dbus_we, dbus_wdata and dbus_be are stable until ack.
  - dbus_ack=1: dbus_req drops on the clock. A load registers the extended dbus_rdata into mem_data; a store leaves mem_data unchanged. Go to DONE.
- State DONE:
  - mem_stall=0 for exactly one cycle, so the pipeline advances and mem_data is valid for MEM/WB.
  - start is ignored, because EX/MEM still holds the completed instruction.
  - Always go to IDLE.
- Minimum latency: start cycle + ack cycle = 2 stall cycles, then DONE.
- Store lanes:
  - Byte: wdata = {4{d[7:0]}}, be = 1<<addr[1:0].
  - Half: wdata = {2{d[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata = d, be = 1111.
  - Loads drive be = 1111 and we = 0.
- Load extract:
  - Byte: select rdata byte addr[1:0].
  - Half: select rdata half addr[1].
  - Extend from bit 7 or bit 15; zero-extend if ex_unsigned=1.
  - Word: pass rdata through.
- If ex_mem_read and ex_mem_write are both 1, the access is a store.
- dbus_ack outside BUSY is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack: dbus_req drops, mem_bus_err pulses for 1 cycle, a load writes mem_data=0, and the state goes to DONE.
  - Ack in the same cycle as the limit wins; no error.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely; mem_bus_err is tied 0; no counter logic.

Test Plan:
- Word load to 0x100, ack on first req cycle, rdata=0xDEADBEEF -> mem_stall high 2 cycles, then DONE with mem_stall=0 and mem_data=0xDEADBEEF; dbus_addr=0x100, be=1111, we=0.
- Signed byte load at 0x103, rdata=0x80FFFF12 -> mem_data=0xFFFFFF80; repeat with ex_unsigned=1 -> 0x00000080.
- Half store at 0x102, data=0x0000ABCD, ack after 3 wait cycles -> dbus_wdata=0xABCDABCD, be=1100, we=1, req held 4 cycles with stable bus fields; mem_stall=1 for 5 cycles.
- Word load at 0x101 -> mem_misalign=1 for 1 cycle, dbus_req never asserts, mem_stall=0.
- reset=0 asserted while BUSY -> dbus_req and mem_stall go 0 immediately; a late ack after release causes no state change.
- With MEM_TIMEOUT_EN and TIMEOUT=4, no ack -> req drops after 4 BUSY cycles, mem_bus_err pulses once, mem_data=0.
